// File: rtl/vector_alu_pipe_if.sv
// Beat-in / result-out handshake bundle for vector_alu_pipe.
// master = producer/consumer side (testbench), slave = the ALU pipeline.
interface vector_alu_pipe_if #(
    parameter int WIDTH   = 4,
    parameter int N_LANES = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH*N_LANES-1:0]     a;
    logic [WIDTH*N_LANES-1:0]     b;
    logic [2:0]                   select;
    logic [N_LANES-1:0]           lane_en;
    logic                         acc_clr;
    logic                         out_valid;
    logic                         out_ready;
    logic [2*WIDTH*N_LANES-1:0]   data_out;
    logic [N_LANES-1:0]           carry_out;
    logic [N_LANES-1:0]           a_greater;
    logic [N_LANES-1:0]           a_equal;
    logic [N_LANES-1:0]           a_less;
    logic [N_LANES-1:0]           inf;

    modport master (
        output in_valid, a, b, select, lane_en, acc_clr, out_ready,
        input  in_ready, out_valid, data_out, carry_out, a_greater, a_equal, a_less, inf
    );

    modport slave (
        input  in_valid, a, b, select, lane_en, acc_clr, out_ready,
        output in_ready, out_valid, data_out, carry_out, a_greater, a_equal, a_less, inf
    );
endinterface

// File: rtl/vector_alu_pipe.sv
// Two-stage N_LANES x WIDTH vector ALU with per-lane MAC accumulators and full-pipe stall.
// Define VALU_MAC_SAT_EN to saturate MAC overflow instead of wrapping.
module valu_lane #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         sel,
    input  logic               en,
    input  logic               clr,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] data,
    output logic               carry,
    output logic               gt,
    output logic               eq,
    output logic               lt,
    output logic               inf,
    output logic               acc_we,
    output logic [2*WIDTH-1:0] acc_nxt
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_AND = 3'b011,
                           OP_OR  = 3'b100, OP_XOR = 3'b101, OP_CMP = 3'b110, OP_MAC = 3'b111;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [W2-1:0]    prod, base, mac_res;
    logic [W2:0]      mac_sum;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    assign prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign base    = clr ? '0 : acc;
    assign mac_sum = {1'b0, base} + {1'b0, prod};
`ifdef VALU_MAC_SAT_EN
    assign mac_res = mac_sum[W2] ? {W2{1'b1}} : mac_sum[W2-1:0];
`else
    assign mac_res = mac_sum[W2-1:0];
`endif

    always_comb begin
        data    = '0;
        carry   = 1'b0;
        gt      = 1'b0;
        eq      = 1'b0;
        lt      = 1'b0;
        inf     = 1'b0;
        acc_we  = 1'b0;
        acc_nxt = '0;
        if (en) begin
            gt = a > b;
            eq = a == b;
            lt = a < b;
            case (sel)
                OP_ADD: begin data = {{(WIDTH-1){1'b0}}, sum}; carry = sum[WIDTH]; end
                OP_SUB: begin data = {{WIDTH{1'b0}}, diff};    carry = a < b;      end
                OP_MUL: data = prod;
                OP_AND: data = {{WIDTH{1'b0}}, a & b};
                OP_OR:  data = {{WIDTH{1'b0}}, a | b};
                OP_XOR: data = {{WIDTH{1'b0}}, a ^ b};
                OP_CMP: data = '0;
                OP_MAC: begin data = mac_res; inf = mac_sum[W2]; end
                default: data = '0;
            endcase
            // A non-MAC beat with acc_clr still zeroes the accumulator.
            acc_we  = (sel == OP_MAC) || clr;
            acc_nxt = (sel == OP_MAC) ? mac_res : '0;
        end
    end
endmodule

module vector_alu_pipe #(
    parameter int WIDTH   = 4,
    parameter int N_LANES = 4
) (
    input  logic              clk,
    input  logic              arst,
    vector_alu_pipe_if.slave  bus
);
    localparam int STAGES = 2;

    logic [STAGES:1]                       vld_pipe_q, vld_pipe_d;
    logic [N_LANES-1:0][WIDTH-1:0]         a_q, a_d, b_q, b_d;
    logic [2:0]                            sel_q, sel_d;
    logic [N_LANES-1:0]                    en_q, en_d;
    logic                                  clr_q, clr_d;
    logic [N_LANES-1:0][2*WIDTH-1:0]       data_q, data_d, acc_q, acc_d;
    logic [N_LANES-1:0]                    carry_q, carry_d, gt_q, gt_d, eq_q, eq_d;
    logic [N_LANES-1:0]                    lt_q, lt_d, inf_q, inf_d;

    logic [N_LANES-1:0][2*WIDTH-1:0]       l_data, l_acc_nxt;
    logic [N_LANES-1:0]                    l_carry, l_gt, l_eq, l_lt, l_inf, l_acc_we;
    logic                                  stall;

    assign stall        = vld_pipe_q[STAGES] && !bus.out_ready;
    assign bus.in_ready = !stall;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        valu_lane #(.WIDTH(WIDTH)) u_lane (
            .a       (a_q[i]),
            .b       (b_q[i]),
            .sel     (sel_q),
            .en      (en_q[i]),
            .clr     (clr_q),
            .acc     (acc_q[i]),
            .data    (l_data[i]),
            .carry   (l_carry[i]),
            .gt      (l_gt[i]),
            .eq      (l_eq[i]),
            .lt      (l_lt[i]),
            .inf     (l_inf[i]),
            .acc_we  (l_acc_we[i]),
            .acc_nxt (l_acc_nxt[i])
        );
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        en_d    = en_q;
        clr_d   = clr_q;
        data_d  = data_q;
        carry_d = carry_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        inf_d   = inf_q;
        acc_d   = acc_q;
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.in_valid};
            if (bus.in_valid) begin
                a_d   = bus.a;
                b_d   = bus.b;
                sel_d = bus.select;
                en_d  = bus.lane_en;
                clr_d = bus.acc_clr;
            end
            // Stage-2 load: the single point where a beat commits to the accumulators.
            if (vld_pipe_q[1]) begin
                data_d  = l_data;
                carry_d = l_carry;
                gt_d    = l_gt;
                eq_d    = l_eq;
                lt_d    = l_lt;
                inf_d   = l_inf;
                for (int i = 0; i < N_LANES; i++)
                    if (l_acc_we[i]) acc_d[i] = l_acc_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            en_q       <= '0;
            clr_q      <= 1'b0;
            data_q     <= '0;
            carry_q    <= '0;
            gt_q       <= '0;
            eq_q       <= '0;
            lt_q       <= '0;
            inf_q      <= '0;
            acc_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            clr_q      <= clr_d;
            data_q     <= data_d;
            carry_q    <= carry_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            inf_q      <= inf_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.data_out  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.a_greater = gt_q;
    assign bus.a_equal   = eq_q;
    assign bus.a_less    = lt_q;
    assign bus.inf       = inf_q;
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe (WIDTH=4, N_LANES=4); honours VALU_MAC_SAT_EN.
module tb_vector_alu_pipe;
    localparam int W = 4;
    localparam int N = 4;
`ifdef VALU_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [2*W*N-1:0] data;
        logic [N-1:0]     cy, gt, eq, lt, inf;
    } exp_t;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    vector_alu_pipe_if #(.WIDTH(W), .N_LANES(N)) bus ();
    vector_alu_pipe #(.WIDTH(W), .N_LANES(N)) dut (.clk(clk), .arst(arst), .bus(bus));

    exp_t sb_q[$];
    int   m_acc[N];
    int   n_cmp = 0, n_err = 0, n_rx = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model, evaluated in acceptance order.
    task automatic model(input logic [W*N-1:0] a, b, input logic [2:0] sel,
                         input logic [N-1:0] en, input logic clr, output exp_t e);
        e = '0;
        for (int i = 0; i < N; i++) begin
            int ai, bi, r, m;
            ai = int'(a[i*W +: W]);
            bi = int'(b[i*W +: W]);
            r  = 0;
            if (en[i]) begin
                e.gt[i] = ai > bi;
                e.eq[i] = ai == bi;
                e.lt[i] = ai < bi;
                case (sel)
                    3'd0: begin r = ai + bi; e.cy[i] = r > 15; end
                    3'd1: begin r = (ai - bi + 16) % 16; e.cy[i] = ai < bi; end
                    3'd2: r = ai * bi;
                    3'd3: r = ai & bi;
                    3'd4: r = ai | bi;
                    3'd5: r = ai ^ bi;
                    3'd6: r = 0;
                    default: begin
                        m = (clr ? 0 : m_acc[i]) + ai * bi;
                        e.inf[i] = m > 255;
                        r = (m > 255) ? (SAT ? 255 : m % 256) : m;
                        m_acc[i] = r;
                    end
                endcase
                if (clr && sel != 3'd7) m_acc[i] = 0;
            end
            e.data[i*2*W +: 2*W] = r[2*W-1:0];
        end
    endtask

    task automatic send(input logic [W*N-1:0] a, b, input logic [2:0] sel,
                        input logic [N-1:0] en, input logic clr);
        bit   rdy;
        exp_t e;
        rdy = 1'b0;
        bus.in_valid = 1'b1; bus.a = a; bus.b = b;
        bus.select = sel; bus.lane_en = en; bus.acc_clr = clr;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) break;
        end
        if (rdy) begin
            model(a, b, sel, en, clr, e);
            sb_q.push_back(e);
        end else chk("send_timeout", 64'd0, 64'd1);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
        #1 chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (arst) begin
            chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else begin
                    e = sb_q.pop_front();
                    n_rx++;
                    chk("data",  64'(bus.data_out),  64'(e.data));
                    chk("carry", 64'(bus.carry_out), 64'(e.cy));
                    chk("cmp",   64'({bus.a_greater, bus.a_equal, bus.a_less}), 64'({e.gt, e.eq, e.lt}));
                    chk("inf",   64'(bus.inf),       64'(e.inf));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rx0;
        logic [2*W*N-1:0] held;
        bit seen;
        arst = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.select = '0;
        bus.lane_en = '0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        #1;
        chk("rst_ov",   64'(bus.out_valid), 64'd0);
        chk("rst_rdy",  64'(bus.in_ready),  64'd1);
        chk("rst_data", 64'(bus.data_out),  64'd0);
        chk("rst_flags", 64'({bus.carry_out, bus.a_greater, bus.a_equal, bus.a_less, bus.inf}), 64'd0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b1;

        // add with carry, plus latency check
        send(16'h000F, 16'h0001, 3'd0, 4'hF, 1'b0);
        @(negedge clk); chk("lat1_ov", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("lat2_ov", 64'(bus.out_valid), 64'd1);
        drain();
        // sub with borrow on lane1 only
        send(16'h0030, 16'h0050, 3'd1, 4'b0010, 1'b0);
        // MAC clear then overflow
        send(16'h000F, 16'h000F, 3'd7, 4'b0001, 1'b1);
        send(16'h000F, 16'h000F, 3'd7, 4'b0001, 1'b0);
        // logic ops, compare, acc_clr on non-MAC (lane3 disabled keeps acc)
        send(16'hA5C3, 16'h3C96, 3'd3, 4'hF, 1'b0);
        send(16'hA5C3, 16'h3C96, 3'd4, 4'hF, 1'b0);
        send(16'hA5C3, 16'h3C96, 3'd5, 4'hF, 1'b0);
        send(16'h7385, 16'h3785, 3'd6, 4'hF, 1'b0);
        send(16'h0000, 16'h0000, 3'd0, 4'b0110, 1'b1);
        send(16'h1111, 16'h1111, 3'd7, 4'hF, 1'b0);
        drain();

        // four muls with a 3-cycle stall at the first result
        rx0 = n_rx;
        bus.out_ready = 1'b0;
        fork
            begin
                send(16'hFEDC, 16'h1234, 3'd2, 4'hF, 1'b0);
                send(16'h9876, 16'hFFFF, 3'd2, 4'hF, 1'b0);
                send(16'h5A5A, 16'hA5A5, 3'd2, 4'hF, 1'b0);
                send(16'h0F0F, 16'h7777, 3'd2, 4'hF, 1'b0);
            end
            begin
                seen = 1'b0;
                held = '0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = bus.out_valid;
                end
                chk("stall_seen", 64'(seen), 64'd1);
                held = bus.data_out;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("stall_rdy",  64'(bus.in_ready),  64'd0);
                    chk("stall_ov",   64'(bus.out_valid), 64'd1);
                    chk("stall_hold", 64'(bus.data_out),  64'(held));
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(n_rx - rx0), 64'd4);

        // random beats under random back-pressure
        fork
            begin
                for (int k = 0; k < 40; k++)
                    send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                         4'($urandom), ($urandom_range(0, 5) == 0));
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        #1 bus.out_ready = 1'b1;
        drain();

        // reset with a MAC beat in flight
        send(16'h0004, 16'h0008, 3'd7, 4'b0001, 1'b1);
        drain();
        send(16'h0001, 16'h0001, 3'd7, 4'b0001, 1'b0);
        @(posedge clk);
        #1 arst = 1'b0;
        sb_q.delete();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        #1;
        chk("arst_ov",   64'(bus.out_valid), 64'd0);
        chk("arst_rdy",  64'(bus.in_ready),  64'd1);
        chk("arst_data", 64'(bus.data_out),  64'd0);
        @(posedge clk);
        #1 arst = 1'b1;
        send(16'h0001, 16'h0001, 3'd7, 4'b0001, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
